// File: rtl/rip_lsu_if.sv
// rip_lsu_if: single-outstanding data-memory port between the RIP load/store
// unit and the data memory.
//   master (LSU):    drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//                    receives mem_gnt, mem_rvalid, mem_rdata.
//   slave  (memory): the mirror image.
interface rip_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rip_lsu.sv
// rip_lsu: load/store unit of the RIP core.
// Takes the registered ALU result as effective address for LB/LH/LW/LBU/LHU/
// SB/SH/SW, issues one request on the data-memory port, and returns extended
// load data. Misaligned accesses are reported as a fault and never reach memory.
//   clk, rst        clock, synchronous active-high reset
//   start, inst     operation valid (sampled in IDLE) and decoded instruction
//   addr, wdata     effective address and store source
//   busy, done      not-idle flag, one-cycle completion pulse
//   ld_data         extended load result (valid with done)
//   misaligned      fault flag (valid with done), fault_addr = offending address
//   mem             data-memory port (master side)
package rip_common;
  typedef struct packed {
    logic add;
    logic sub;
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
    logic sb;
    logic sh;
    logic sw;
  } inst_t;
endpackage

module rip_lsu (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  rip_common::inst_t inst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       ld_data,
  output logic              misaligned,
  output logic [31:0]       fault_addr,
  rip_lsu_if.master         mem
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic        load_q, load_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [31:0] fault_q, fault_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] maddr_q, maddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] mwd_q, mwd_d;

  // Request decode from the incoming instruction
  logic [7:0]  ls_flags;
  logic        ls_one;
  logic        is_store;
  size_e       req_size;
  logic        req_aligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] rd_shift;
  logic [31:0] rd_fmt;
  logic        unused_inst;

  assign unused_inst = inst.add ^ inst.sub;
  assign ls_flags = {inst.lb, inst.lh, inst.lw, inst.lbu, inst.lhu, inst.sb, inst.sh, inst.sw};
  assign ls_one   = ($countones(ls_flags) == 1);
  assign is_store = inst.sb | inst.sh | inst.sw;

  always_comb begin
    req_size    = SZ_W;
    req_aligned = (addr[1:0] == 2'b00);
    req_be      = 4'b1111;
    req_wd      = wdata;
    if (inst.lb || inst.lbu || inst.sb) begin
      req_size    = SZ_B;
      req_aligned = 1'b1;
      req_be      = 4'b0001 << addr[1:0];
      req_wd      = {4{wdata[7:0]}};
    end else if (inst.lh || inst.lhu || inst.sh) begin
      req_size    = SZ_H;
      req_aligned = ~addr[0];
      req_be      = 4'b0011 << addr[1:0];
      req_wd      = {2{wdata[15:0]}};
    end
  end

  // Response lane is selected by the latched byte offset
  assign rd_shift = mem.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      SZ_B:    rd_fmt = uns_q ? {24'b0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_H:    rd_fmt = uns_q ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_fmt = rd_shift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    load_d    = load_q;
    uns_d     = uns_q;
    off_d     = off_q;
    fault_d   = fault_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    be_d      = be_q;
    mwd_d     = mwd_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    ld_data_d = '0;
    case (state_q)
      S_IDLE: begin
        if (start && ls_one) begin
          size_d = req_size;
          load_d = ~is_store;
          uns_d  = inst.lbu | inst.lhu;
          off_d  = addr[1:0];
          if (!req_aligned) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            fault_d = addr;
          end else begin
            state_d = S_REQ;
            we_d    = is_store;
            maddr_d = {addr[31:2], 2'b00};
            be_d    = req_be;
            mwd_d   = req_wd;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_gnt) begin
          if (load_q) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          ld_data_d = rd_fmt;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // busy and mem_req are registered copies of where the FSM is heading
    busy_d = (state_d != S_IDLE);
    req_d  = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      size_q    <= SZ_B;
      load_q    <= 1'b0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      ld_data_q <= '0;
      fault_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= '0;
      be_q      <= '0;
      mwd_q     <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      load_q    <= load_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      ld_data_q <= ld_data_d;
      fault_q   <= fault_d;
      req_q     <= req_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      be_q      <= be_d;
      mwd_q     <= mwd_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign ld_data       = ld_data_q;
  assign misaligned    = mis_q;
  assign fault_addr    = fault_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = mwd_q;

endmodule
